// File: rtl/calc_pkg.sv
// Shared types and glyph helpers for the calculator display path.
// Segments are active-low, seg[0] = a ... seg[6] = g.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OP1    = 2'd1,
    OP2    = 2'd2,
    RESULT = 2'd3
  } phase_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_ONE   = 7'h79;
  localparam logic [6:0] SEG_TWO   = 7'h24;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0:    hex2seg = 7'h40;
      4'h1:    hex2seg = 7'h79;
      4'h2:    hex2seg = 7'h24;
      4'h3:    hex2seg = 7'h30;
      4'h4:    hex2seg = 7'h19;
      4'h5:    hex2seg = 7'h12;
      4'h6:    hex2seg = 7'h02;
      4'h7:    hex2seg = 7'h78;
      4'h8:    hex2seg = 7'h00;
      4'h9:    hex2seg = 7'h10;
      4'hA:    hex2seg = 7'h08;
      4'hB:    hex2seg = 7'h03;
      4'hC:    hex2seg = 7'h46;
      4'hD:    hex2seg = 7'h21;
      4'hE:    hex2seg = 7'h06;
      default: hex2seg = 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: W cycles per conversion, restartable, abortable.
// bcd only changes on the done cycle so consumers never see partial values.
module bin2bcd_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [11:0]  bcd
);
  localparam int CW = $clog2(W + 1);

  logic [11+W:0] sh_q, sh_d, sh_adj, sh_next;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [11:0]   bcd_q, bcd_d;

  always_comb begin
    sh_adj = sh_q;
    for (int i = 0; i < 3; i++) begin
      if (sh_q[W+4*i +: 4] >= 4'd5) sh_adj[W+4*i +: 4] = sh_q[W+4*i +: 4] + 4'd3;
    end
    sh_next = {sh_adj[10+W:0], 1'b0};
  end

  // abort beats start, start beats an in-flight shift (latest value wins)
  assign done = busy_q && !abort && !start && (cnt_q == CW'(1));

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    bcd_d  = bcd_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      sh_d   = {12'd0, bin};
      cnt_d  = CW'(W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      sh_d  = sh_next;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        bcd_d  = sh_next[11+W:W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      bcd_q  <= '0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      bcd_q  <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/calc_display_driver.sv
// Calculator display driver: phase FSM, BCD conversion of the result and a
// 4-digit multiplexed seven-segment scan with registered seg/an outputs.
module calc_display_driver
  import calc_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int RES_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [3:0]       operand1,
  input  logic [3:0]       operand2,
  input  logic             confirmed_operand1,
  input  logic             confirmed_operand2,
  input  logic [RES_W-1:0] result,
  input  logic             result_neg,
  input  logic             result_valid,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             dp,
  output logic             busy
);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  phase_t        phase_q, phase_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [1:0]    dig_q, dig_d;
  logic          neg_q, neg_d;
  logic          disp_neg_q, disp_neg_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          conv_done;
  logic [11:0]   bcd;
  logic          wrap;
  logic [3:0][6:0] glyph;

  bin2bcd_seq #(.W(RES_W)) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (result_valid && !clear),
    .abort (clear),
    .bin   (result),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = IDLE;
    end else if (conv_done && (phase_q == OP1 || phase_q == OP2)) begin
      phase_d = RESULT;
    end else begin
      case (phase_q)
        IDLE:    if (confirmed_operand1) phase_d = OP1;
        OP1:     if (confirmed_operand2) phase_d = OP2;
        default: phase_d = phase_q;
      endcase
    end
  end

  // sign follows its own conversion so the dash appears together with the digits
  always_comb begin
    neg_d      = (result_valid && !clear) ? result_neg : neg_q;
    disp_neg_d = conv_done ? neg_q : disp_neg_q;
  end

  assign wrap  = (ref_q == RW'(REFRESH_DIV - 1));
  assign ref_d = wrap ? '0 : ref_q + 1'b1;
  assign dig_d = wrap ? dig_q + 2'd1 : dig_q;

  always_comb begin
    glyph = {4{SEG_BLANK}};
    case (phase_q)
      IDLE: glyph = {4{SEG_DASH}};
      OP1: begin
        glyph[3] = SEG_ONE;
        glyph[0] = hex2seg(operand1);
      end
      OP2: begin
        glyph[3] = SEG_TWO;
        glyph[0] = hex2seg(operand2);
      end
      default: begin
        glyph[3] = (disp_neg_q && bcd != 12'd0) ? SEG_DASH : SEG_BLANK;
        glyph[2] = (bcd[11:8] != 4'd0) ? hex2seg(bcd[11:8]) : SEG_BLANK;
        glyph[1] = (bcd[11:4] != 8'd0) ? hex2seg(bcd[7:4]) : SEG_BLANK;
        glyph[0] = hex2seg(bcd[3:0]);
      end
    endcase
    seg_d = glyph[dig_q];
    an_d  = ~(4'b0001 << dig_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= IDLE;
      ref_q      <= '0;
      dig_q      <= 2'd0;
      neg_q      <= 1'b0;
      disp_neg_q <= 1'b0;
      seg_q      <= SEG_BLANK;
      an_q       <= 4'hF;
    end else begin
      phase_q    <= phase_d;
      ref_q      <= ref_d;
      dig_q      <= dig_d;
      neg_q      <= neg_d;
      disp_neg_q <= disp_neg_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_calc_display_driver.sv
// Bench for calc_display_driver: expected display frames are queued by the
// stimulus and compared digit by digit by an independent scan monitor.
module tb_calc_display_driver;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [3:0] operand1, operand2;
  logic       conf1, conf2;
  logic [7:0] result;
  logic       result_neg, result_valid;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string           name;
    logic [3:0][6:0] seg;
  } frame_t;

  frame_t exp_q[$];

  calc_display_driver #(.REFRESH_DIV(4), .RES_W(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .clear              (clear),
    .operand1           (operand1),
    .operand2           (operand2),
    .confirmed_operand1 (conf1),
    .confirmed_operand2 (conf2),
    .result             (result),
    .result_neg         (result_neg),
    .result_valid       (result_valid),
    .seg                (seg),
    .an                 (an),
    .dp                 (dp),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input string nm, input logic [3:0][6:0] s);
    frame_t f;
    f.name = nm;
    f.seg  = s;
    exp_q.push_back(f);
  endtask

  task automatic wait_drain(input string nm);
    int c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check({nm, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 30) begin
      n++;
      tick();
    end
  endtask

  // scan monitor: one full pass over the four anodes per queued frame
  initial begin : monitor
    frame_t     f;
    logic [3:0] seen;
    int         cyc;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        f    = exp_q[0];
        seen = 4'h0;
        cyc  = 0;
        while (seen != 4'hF && cyc < 40) begin
          for (int d = 0; d < 4; d++) begin
            if (an == ~(4'b0001 << d) && !seen[d]) begin
              check($sformatf("%s_d%0d", f.name, d), 32'(seg), 32'(f.seg[d]));
              seen[d] = 1'b1;
            end
          end
          if (seen != 4'hF) begin
            @(negedge clk);
            cyc++;
          end
        end
        check({f.name, "_scan"}, 32'(seen), 32'hF);
        check({f.name, "_dp"}, 32'(dp), 32'd1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst_n = 1'b1;
    clear = 1'b0;
    operand1 = 4'h0;
    operand2 = 4'h0;
    conf1 = 1'b0;
    conf2 = 1'b0;
    result = 8'd0;
    result_neg = 1'b0;
    result_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    #20 rst_n = 1'b1;

    // reset mid-scan takes effect without a clock edge
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("scan_an_%0d", k), 32'(an), 32'(4'(~(4'b0001 << ((k - 1) / 4)))));
    end

    push_frame("idle", {7'h3F, 7'h3F, 7'h3F, 7'h3F});
    wait_drain("idle");

    tick();
    operand1 = 4'hA;
    conf1 = 1'b1;
    tick();
    tick();
    push_frame("op1", {7'h79, 7'h7F, 7'h7F, 7'h08});
    wait_drain("op1");

    tick();
    operand2 = 4'h3;
    conf2 = 1'b1;
    tick();
    tick();
    push_frame("op2", {7'h24, 7'h7F, 7'h7F, 7'h30});
    wait_drain("op2");

    tick();
    result = 8'd130;
    result_neg = 1'b0;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    count_busy(n);
    check("busy_130", 32'(n), 32'd8);
    tick();
    push_frame("r130", {7'h7F, 7'h79, 7'h30, 7'h40});
    wait_drain("r130");

    // second pulse three cycles into a conversion restarts it
    tick();
    result = 8'd7;
    result_neg = 1'b1;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    tick();
    tick();
    result = 8'd200;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    count_busy(n);
    check("busy_restart", 32'(n), 32'd8);
    tick();
    push_frame("rneg200", {7'h3F, 7'h24, 7'h40, 7'h40});
    wait_drain("rneg200");

    tick();
    result = 8'd0;
    result_neg = 1'b1;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    count_busy(n);
    check("busy_zero", 32'(n), 32'd8);
    tick();
    push_frame("rzero", {7'h7F, 7'h7F, 7'h7F, 7'h40});
    wait_drain("rzero");

    // clear wins over a simultaneous result_valid
    tick();
    clear = 1'b1;
    result = 8'd55;
    result_neg = 1'b0;
    result_valid = 1'b1;
    conf1 = 1'b0;
    conf2 = 1'b0;
    tick();
    clear = 1'b0;
    result_valid = 1'b0;
    check("clr_busy0", 32'(busy), 32'd0);
    tick();
    tick();
    check("clr_busy2", 32'(busy), 32'd0);
    push_frame("cleared", {7'h3F, 7'h3F, 7'h3F, 7'h3F});
    wait_drain("cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
